// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - core/host arbiter in front of a single-port data-memory BRAM
// Optional DMEM_ARB_PERF_EN adds grant and conflict performance counters.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]       perf_core_cnt,
    output logic [15:0]       perf_host_cnt,
    output logic [15:0]       perf_conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_CORE = 2'd1,
        S_RD_HOST = 2'd2
    } state_t;

    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_starve_cnt;
    logic                r_core_rvalid;
    logic                r_host_rvalid;
    logic [DATA_W-1:0]   r_core_rdata;
    logic [DATA_W-1:0]   r_host_rdata;
    logic                w_host_wins;

    // Host overrides the core only once it has been starved long enough.
    assign w_host_wins = host_req && (!core_req || (r_starve_cnt >= LP_LIMIT));

    always_comb begin
        core_gnt     = 1'b0;
        host_gnt     = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_din      = '0;
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!reset) begin
                    if (w_host_wins) begin
                        host_gnt = 1'b1;
                        mem_en   = 1'b1;
                        mem_we   = host_we;
                        mem_addr = host_addr;
                        mem_din  = host_wdata;
                        if (!host_we) w_next_state = S_RD_HOST;
                    end else if (core_req) begin
                        core_gnt = 1'b1;
                        mem_en   = 1'b1;
                        mem_we   = core_we;
                        mem_addr = core_addr;
                        mem_din  = core_wdata;
                        if (!core_we) w_next_state = S_RD_CORE;
                    end
                end
            end
            S_RD_CORE: w_next_state = S_IDLE;
            S_RD_HOST: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_starve_cnt  <= 4'd0;
            r_core_rvalid <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_core_rdata  <= '0;
            r_host_rdata  <= '0;
        end else begin
            r_state       <= w_next_state;
            r_core_rvalid <= (r_state == S_RD_CORE);
            r_host_rvalid <= (r_state == S_RD_HOST);
            if (r_state == S_RD_CORE) r_core_rdata <= mem_dout;
            if (r_state == S_RD_HOST) r_host_rdata <= mem_dout;
            // Denials during read-return cycles count toward starvation too.
            if (host_req && !host_gnt) begin
                if (r_starve_cnt != 4'hF) r_starve_cnt <= r_starve_cnt + 4'd1;
            end else begin
                r_starve_cnt <= 4'd0;
            end
        end
    end

    assign core_rvalid = r_core_rvalid;
    assign host_rvalid = r_host_rvalid;
    assign core_rdata  = r_core_rdata;
    assign host_rdata  = r_host_rdata;

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] r_perf_core;
    logic [15:0] r_perf_host;
    logic [15:0] r_perf_conflict;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_core     <= 16'd0;
            r_perf_host     <= 16'd0;
            r_perf_conflict <= 16'd0;
        end else begin
            if (core_gnt) r_perf_core <= r_perf_core + 16'd1;
            if (host_gnt) r_perf_host <= r_perf_host + 16'd1;
            if ((r_state == S_IDLE) && core_req && host_req)
                r_perf_conflict <= r_perf_conflict + 16'd1;
        end
    end

    assign perf_core_cnt     = r_perf_core;
    assign perf_host_cnt     = r_perf_host;
    assign perf_conflict_cnt = r_perf_conflict;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter with BRAM and reference models
module tb_dmem_port_arbiter;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          host_req = 1'b0, host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          core_gnt, core_rvalid, host_gnt, host_rvalid;
    logic [DW-1:0] core_rdata, host_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0]   perf_core_cnt, perf_host_cnt, perf_conflict_cnt;
    int            m_pc = 0, m_ph = 0, m_pconf = 0;
`endif

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
`ifdef DMEM_ARB_PERF_EN
        , .perf_core_cnt(perf_core_cnt), .perf_host_cnt(perf_host_cnt),
        .perf_conflict_cnt(perf_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 8'h20) ? 32'h12345678 : {24'h00C0DE, a};
    endfunction

    // BRAM model: read-first, one-cycle read latency
    logic [DW-1:0] mem_arr [0:255];
    bit            mem_wr  [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_arr[mem_addr] <= mem_din;
                mem_wr[mem_addr]  <= 1'b1;
            end
            mem_dout <= mem_wr[mem_addr] ? mem_arr[mem_addr] : init_val(mem_addr);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t cq[$];
    exp_t hq[$];

    // Reference model: grant prediction, memory shadow, expected read responses
    logic [DW-1:0] shadow   [0:255];
    bit            shadow_w [0:255];
    bit            m_busy   = 1'b0;
    int            m_starve = 0;

    function automatic logic [DW-1:0] sh_rd(input logic [AW-1:0] a);
        return shadow_w[a] ? shadow[a] : init_val(a);
    endfunction

    always @(negedge clk) begin
        bit pc, ph;
        logic [41:0] exp_mem;
        if (reset) begin
            chk("rst_gnt", 64'({core_gnt, host_gnt}), 64'd0);
            chk("rst_mem", 64'({mem_en, mem_we, mem_addr, mem_din}), 64'd0);
            chk("rst_rvalid", 64'({core_rvalid, host_rvalid}), 64'd0);
            chk("rst_rdata", {core_rdata, host_rdata}, 64'd0);
            m_busy   = 1'b0;
            m_starve = 0;
            cq.delete();
            hq.delete();
`ifdef DMEM_ARB_PERF_EN
            m_pc = 0; m_ph = 0; m_pconf = 0;
`endif
        end else begin
            ph = !m_busy && host_req && (!core_req || m_starve >= LIMIT);
            pc = !m_busy && core_req && !ph;
            chk("gnt", 64'({core_gnt, host_gnt}), 64'({pc, ph}));
            if (ph)      exp_mem = {1'b1, host_we, host_addr, host_wdata};
            else if (pc) exp_mem = {1'b1, core_we, core_addr, core_wdata};
            else         exp_mem = '0;
            chk("mem_drive", 64'({mem_en, mem_we, mem_addr, mem_din}), 64'(exp_mem));
`ifdef DMEM_ARB_PERF_EN
            if (pc) m_pc++;
            if (ph) m_ph++;
            if (!m_busy && core_req && host_req) m_pconf++;
`endif
            if (pc) begin
                if (core_we) begin shadow[core_addr] = core_wdata; shadow_w[core_addr] = 1'b1; end
                else cq.push_back('{sh_rd(core_addr), cyc + 2});
            end
            if (ph) begin
                if (host_we) begin shadow[host_addr] = host_wdata; shadow_w[host_addr] = 1'b1; end
                else hq.push_back('{sh_rd(host_addr), cyc + 2});
            end
            m_busy   = (pc && !core_we) || (ph && !host_we);
            m_starve = (host_req && !ph) ? ((m_starve >= 15) ? 15 : m_starve + 1) : 0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents read data
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (core_rvalid) begin
                if (cq.size() == 0) chk("core_rvalid_unexpected", 64'd1, 64'd0);
                else begin
                    e = cq.pop_front();
                    chk("core_rdata", 64'(core_rdata), 64'(e.data));
                    chk("core_rlatency", 64'(cyc), 64'(e.due));
                end
            end
            if (host_rvalid) begin
                if (hq.size() == 0) chk("host_rvalid_unexpected", 64'd1, 64'd0);
                else begin
                    e = hq.pop_front();
                    chk("host_rdata", 64'(host_rdata), 64'(e.data));
                    chk("host_rlatency", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    // Requester models: 0 idle, 1 requesting, 2 awaiting read data
    int c_st = 0, h_st = 0;
    bit core_wr_only = 1'b0;
    bit obs_cv, obs_hv;

    task automatic start_core(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d; c_st = 1;
    endtask

    task automatic start_host(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; h_st = 1;
    endtask

    task automatic cyc_step(input int cpct, input int hpct, output bit cg, output bit hg);
        @(negedge clk);
        cg = core_gnt; hg = host_gnt; obs_cv = core_rvalid; obs_hv = host_rvalid;
        @(posedge clk);
        #1;
        if (c_st == 1 && cg) begin core_req = 1'b0; c_st = core_we ? 0 : 2; end
        else if (c_st == 1 && cpct > 0 && cpct < 100 && $urandom_range(0, 99) < 3) begin
            core_req = 1'b0; c_st = 0;
        end
        if (c_st == 2 && obs_cv) c_st = 0;
        if (c_st == 0 && cpct > 0 && $urandom_range(1, 100) <= cpct)
            start_core(core_wr_only ? 1'b1 : 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 15)), $urandom);
        if (h_st == 1 && hg) begin host_req = 1'b0; h_st = host_we ? 0 : 2; end
        else if (h_st == 1 && hpct > 0 && $urandom_range(0, 99) < 3) begin
            host_req = 1'b0; h_st = 0;
        end
        if (h_st == 2 && obs_hv) h_st = 0;
        if (h_st == 0 && hpct > 0 && $urandom_range(1, 100) <= hpct)
            start_host(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
    endtask

    task automatic drain();
        bit cg, hg;
        for (int i = 0; i < 60; i++) begin
            if (c_st == 0 && h_st == 0) break;
            cyc_step(0, 0, cg, hg);
        end
        chk("drain_done", 64'({c_st == 0, h_st == 0}), 64'd3);
        repeat (3) cyc_step(0, 0, cg, hg);
    endtask

    initial begin
        bit cg, hg;
        int denied, rv_cnt;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        start_core(1'b1, 8'h10, 32'hDEADBEEF);
        cyc_step(0, 0, cg, hg);
        chk("t1_wr_gnt", 64'(cg), 64'd1);
        drain();
        start_core(1'b0, 8'h10, 32'h0);
        drain();
        chk("t1_rd_data", 64'(core_rdata), 64'hDEADBEEF);

        start_host(1'b0, 8'h20, 32'h0);
        drain();
        chk("t2_host_rdata", 64'(host_rdata), 64'h12345678);

        core_wr_only = 1'b1;
        start_core(1'b1, 8'h01, $urandom);
        start_host(1'b1, 8'h05, 32'hA5A5_0005);
        denied = 0;
        for (int i = 0; i < 20; i++) begin
            cyc_step(100, 0, cg, hg);
            if (hg) break;
            denied++;
        end
        chk("t3_host_denied_cycles", 64'(denied), 64'(LIMIT));
        cyc_step(100, 0, cg, hg);
        chk("t3_core_regrant", 64'(cg), 64'd1);
        core_wr_only = 1'b0;
        drain();

        start_core(1'b0, 8'h03, 32'h0);
        cyc_step(0, 0, cg, hg);
        chk("t4_core_rd_gnt", 64'(cg), 64'd1);
        start_host(1'b0, 8'h04, 32'h0);
        cyc_step(0, 0, cg, hg);
        chk("t4_no_gnt_in_rd", 64'({cg, hg}), 64'd0);
        cyc_step(0, 0, cg, hg);
        chk("t4_host_gnt_after", 64'(hg), 64'd1);
        drain();

        start_host(1'b0, 8'h07, 32'h0);
        cyc_step(0, 0, cg, hg);
        chk("t5_host_rd_gnt", 64'(hg), 64'd1);
        reset = 1'b1;
        core_req = 1'b0; host_req = 1'b0; c_st = 0; h_st = 0;
        repeat (2) cyc_step(0, 0, cg, hg);
        reset = 1'b0;
        rv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc_step(0, 0, cg, hg);
            if (obs_hv) rv_cnt++;
        end
        chk("t5_no_host_rvalid", 64'(rv_cnt), 64'd0);
        start_core(1'b0, 8'h10, 32'h0);
        drain();
        chk("t5_core_rd_after_rst", 64'(core_rdata), 64'hDEADBEEF);

        for (int i = 0; i < 3000; i++) cyc_step(50, 50, cg, hg);
        drain();
        chk("core_queue_empty", 64'(cq.size()), 64'd0);
        chk("host_queue_empty", 64'(hq.size()), 64'd0);
`ifdef DMEM_ARB_PERF_EN
        chk("perf_core", 64'(perf_core_cnt), 64'(m_pc[15:0]));
        chk("perf_host", 64'(perf_host_cnt), 64'(m_ph[15:0]));
        chk("perf_conflict", 64'(perf_conflict_cnt), 64'(m_pconf[15:0]));
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
